// File: rtl/inv_subbytes.sv
// Inverse byte-substitution stage. Builds inv[S[i]] = i from a serial forward
// S-box stream, flags non-permutation streams, then maps each byte of a word
// through the inverse table with one registered cycle of latency.
`timescale 1ns/1ps
module inv_subbytes #(
    parameter int unsigned SBOX_WIDTH = 8,
    parameter int unsigned SBOX_DEPTH = 256,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sbox_reload,
    input  logic                  sbox_valid,
    input  logic [SBOX_WIDTH-1:0] sbox_out,
    output logic                  sbox_ready,
    output logic                  sbox_error,
    output logic                  tready,
    input  logic                  tvalid,
    input  logic [DATA_WIDTH-1:0] in,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] out
);

    localparam int unsigned NUM_BYTES = DATA_WIDTH / SBOX_WIDTH;

    typedef enum logic [1:0] {StLoad, StReady, StError} state_e;

    state_e                  state_q, state_d;
    logic [SBOX_WIDTH-1:0]   index_q, index_d;
    logic [SBOX_DEPTH-1:0]   seen_q, seen_d;
    logic                    dup_q, dup_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic [DATA_WIDTH-1:0]   lookup;
    logic                    load_beat;
    logic                    beat_dup;
    logic                    last_beat;

    // Reload and reset both drop a beat arriving in the same cycle.
    assign load_beat = (state_q == StLoad) && sbox_valid && !sbox_reload && !reset;
    assign beat_dup  = seen_q[sbox_out];
    assign last_beat = (index_q == SBOX_WIDTH'(SBOX_DEPTH - 1));

    // One replicated table per byte lane so every lane reads in parallel.
    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
        logic [SBOX_WIDTH-1:0] mem [SBOX_DEPTH];

        // Table write: inv[S[index]] = index; contents are never cleared.
        always_ff @(posedge clk) begin
            if (load_beat) begin
                mem[sbox_out] <= index_q;
            end
        end

        assign lookup[g*SBOX_WIDTH +: SBOX_WIDTH] = mem[in[g*SBOX_WIDTH +: SBOX_WIDTH]];
    end

    // Next-state: loading, permutation check and registered lookup.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        seen_d  = seen_q;
        dup_d   = dup_q;
        valid_d = 1'b0;
        out_d   = out_q;
        if (sbox_reload) begin
            state_d = StLoad;
            index_d = '0;
            seen_d  = '0;
            dup_d   = 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (sbox_valid) begin
                        seen_d[sbox_out] = 1'b1;
                        dup_d            = dup_q | beat_dup;
                        index_d          = index_q + SBOX_WIDTH'(1);
                        // 256 distinct values are a permutation; duplicates are all we track.
                        if (last_beat) begin
                            state_d = (dup_q || beat_dup) ? StError : StReady;
                        end
                    end
                end
                StReady: begin
                    if (tvalid) begin
                        valid_d = 1'b1;
                        out_d   = lookup;
                    end
                end
                StError: begin
                end
                default: state_d = StLoad;
            endcase
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StLoad;
            index_q <= '0;
            seen_q  <= '0;
            dup_q   <= 1'b0;
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            seen_q  <= seen_d;
            dup_q   <= dup_d;
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign sbox_ready = (state_q == StReady);
    assign tready     = sbox_ready;
    assign sbox_error = (state_q == StError);
    assign valid      = valid_q;
    assign out        = out_q;

endmodule

// File: tb/tb_inv_subbytes.sv
// Directed bench for inv_subbytes with a scoreboard of expected lookup words.
`timescale 1ns/1ps
module tb_inv_subbytes;

    localparam logic [127:0] ID_IN   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] REV_OUT = 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0;

    logic         clk = 1'b0;
    logic         reset;
    logic         sbox_reload;
    logic         sbox_valid;
    logic [7:0]   sbox_out;
    logic         sbox_ready;
    logic         sbox_error;
    logic         tready;
    logic         tvalid;
    logic [127:0] in_w;
    logic         valid;
    logic [127:0] out_w;

    int           n_checks = 0;
    int           n_pass = 0;
    int           cyc = 0;
    logic [127:0] exp_q[$];
    int           exp_cyc_q[$];
    logic [7:0]   tbl [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inv_subbytes #(
        .SBOX_WIDTH(8),
        .SBOX_DEPTH(256),
        .DATA_WIDTH(128)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sbox_reload(sbox_reload),
        .sbox_valid (sbox_valid),
        .sbox_out   (sbox_out),
        .sbox_ready (sbox_ready),
        .sbox_error (sbox_error),
        .tready     (tready),
        .tvalid     (tvalid),
        .in         (in_w),
        .valid      (valid),
        .out        (out_w)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Scoreboard: each accepted word must come out exactly one cycle later.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0 && exp_cyc_q[0] + 1 == cyc) begin
            check("valid_after_tvalid", 128'(valid), 128'(1'b1));
            check("lookup_out", out_w, exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end else if (valid === 1'b1) begin
            check("unexpected_valid", 128'(valid), 128'(1'b0));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a = a_in;
        logic [7:0] b = b_in;
        logic [7:0] p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] b;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        b = inv;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    // All stimulus tasks start and end on a falling edge.
    task automatic beat(input logic [7:0] v);
        sbox_valid = 1'b1;
        sbox_out   = v;
        @(negedge clk);
        sbox_valid = 1'b0;
    endtask

    task automatic load(input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            beat(tbl[i]);
            if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
    endtask

    task automatic word(input logic [127:0] w, input logic [127:0] e, input bit acc);
        tvalid = 1'b1;
        in_w   = w;
        if (acc) begin
            exp_q.push_back(e);
            exp_cyc_q.push_back(cyc);
        end
        @(negedge clk);
        tvalid = 1'b0;
    endtask

    task automatic reload();
        sbox_reload = 1'b1;
        @(negedge clk);
        sbox_reload = 1'b0;
    endtask

    task automatic set_identity();
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i);
    endtask

    task automatic set_reversed();
        for (int i = 0; i < 256; i++) tbl[i] = 8'(255 - i);
    endtask

    initial begin
        reset       = 1'b1;
        sbox_reload = 1'b0;
        sbox_valid  = 1'b0;
        sbox_out    = 8'h00;
        tvalid      = 1'b0;
        in_w        = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", 128'(valid), 128'(1'b0));
        check("rst_out", out_w, 128'h0);
        check("rst_ready", 128'(sbox_ready), 128'(1'b0));
        check("rst_error", 128'(sbox_error), 128'(1'b0));
        check("rst_tready", 128'(tready), 128'(1'b0));
        reset = 1'b0;

        // Identity stream.
        set_identity();
        load(255, 0);
        check("id_ready_before_last", 128'(sbox_ready), 128'(1'b0));
        beat(tbl[255]);
        check("id_ready", 128'(sbox_ready), 128'(1'b1));
        check("id_tready", 128'(tready), 128'(1'b1));
        check("id_error", 128'(sbox_error), 128'(1'b0));
        word(ID_IN, ID_IN, 1'b1);
        @(negedge clk);

        // AES forward S-box, two back-to-back lookups.
        reload();
        check("aes_ready_after_reload", 128'(sbox_ready), 128'(1'b0));
        for (int i = 0; i < 256; i++) tbl[i] = aes_sbox(8'(i));
        load(256, 0);
        check("aes_ready", 128'(sbox_ready), 128'(1'b1));
        word({16{8'h63}}, {16{8'h00}}, 1'b1);
        word({16{8'hED}}, {16{8'h53}}, 1'b1);
        @(negedge clk);

        // Reversed stream with random gaps.
        reload();
        set_reversed();
        load(255, 3);
        check("rev_ready_before_last", 128'(sbox_ready), 128'(1'b0));
        beat(tbl[255]);
        check("rev_ready", 128'(sbox_ready), 128'(1'b1));
        word(ID_IN, REV_OUT, 1'b1);
        @(negedge clk);

        // Non-permutation: S[5] = S[9] = 0, value 1 missing.
        reload();
        set_identity();
        tbl[0] = 8'h05;
        tbl[1] = 8'h09;
        tbl[5] = 8'h00;
        tbl[9] = 8'h00;
        load(256, 0);
        check("dup_error", 128'(sbox_error), 128'(1'b1));
        check("dup_ready", 128'(sbox_ready), 128'(1'b0));
        check("dup_tready", 128'(tready), 128'(1'b0));
        word(ID_IN, '0, 1'b0);
        repeat (2) @(negedge clk);
        reload();
        check("dup_error_cleared", 128'(sbox_error), 128'(1'b0));
        set_identity();
        load(256, 0);
        check("dup_recover_ready", 128'(sbox_ready), 128'(1'b1));
        check("dup_recover_error", 128'(sbox_error), 128'(1'b0));
        word(ID_IN, ID_IN, 1'b1);
        @(negedge clk);

        // Reload mid-load: no stale reversed entries survive.
        reload();
        set_reversed();
        load(100, 0);
        check("partial_ready", 128'(sbox_ready), 128'(1'b0));
        reload();
        set_identity();
        load(255, 0);
        check("reload_ready_before_last", 128'(sbox_ready), 128'(1'b0));
        beat(tbl[255]);
        check("reload_ready", 128'(sbox_ready), 128'(1'b1));
        word(REV_OUT, REV_OUT, 1'b1);
        word(ID_IN, ID_IN, 1'b1);
        @(negedge clk);

        // Reset in READY together with tvalid.
        reset = 1'b1;
        word(ID_IN, '0, 1'b0);
        reset = 1'b0;
        check("rst_ready_valid", 128'(valid), 128'(1'b0));
        check("rst_ready_out", out_w, 128'h0);
        check("rst_ready_sbox_ready", 128'(sbox_ready), 128'(1'b0));
        word(ID_IN, '0, 1'b0);
        @(negedge clk);
        check("rst_ignored_out", out_w, 128'h0);
        load(256, 0);
        check("rst_reload_ready", 128'(sbox_ready), 128'(1'b1));
        word(ID_IN, ID_IN, 1'b1);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 128'(exp_q.size()), 128'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
